gpu_regfile_ctl: RTL and testbench
==================================

Name: gpu_regfile_ctl

Overview:
- Access controller and initiator for the GPU 64x32 dual-port register-file RAM.
- Accepts operand-fetch requests (two source registers) and ALU writeback requests.
- Drives both RAM ports, holds writebacks in a small queue and forwards queued data to reads, so callers see coherent register values despite RAM latency and write deferral.
- Sits between the GPU instruction pipe and the register-file RAM.

Parameters:
- WB_DEPTH, 4, writeback queue depth (power of 2, 2..8).
- AW, 6, register address width.
- DW, 32, register data width.

Ports:
- sys_clk  in  1  single system clock; all logic on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- rd_valid  in  1  operand fetch request.
- rd_ready  out  1  fetch accepted when rd_valid & rd_ready.
- rd_srca  in  AW  source A register.
- rd_srcb  in  AW  source B register.
- op_valid  out  1  operands valid (one-cycle pulse per accepted fetch).
- op_a  out  DW  source A value.
- op_b  out  DW  source B value.
- wb_valid  in  1  writeback request.
- wb_ready  out  1  high when the queue is not full.
- wb_addr  in  AW  destination register.
- wb_data  in  DW  write data.
- ram_aa  out  AW  RAM port A address.
- ram_da  out  DW  RAM port A write data (tied to 0; port A is read-only).
- ram_nwea  out  1  RAM port A write strobe, active-low (held 1).
- ram_clka  out  1  RAM port A enable.
- ram_ab  out  AW  RAM port B address.
- ram_db  out  DW  RAM port B write data.
- ram_nweb  out  1  RAM port B write strobe, active-low.
- ram_clkb  out  1  RAM port B enable.
- ram_qa  in  DW  RAM port A read data, registered, 1-cycle latency.
- ram_qb  in  DW  RAM port B read data, registered, 1-cycle latency.

Behaviour:
- Reset values:
  - queue empty; op_valid=0; op_a=op_b=0.
  - ram_nwea=ram_nweb=1; ram_clka=ram_clkb=0; addresses and data 0.
  - Reset mid-operation discards queued writebacks and any in-flight fetch.
- Queue: FIFO of {addr,data}.
  - wb_ready = !full.
  - Push on wb_valid & wb_ready; pop when the head is issued.
  - Push and pop in the same cycle are legal, including when full: wb_ready stays low while full, so no push is accepted that cycle.
- Per-cycle arbitration. Each cycle is exactly one of:
  - READ: rd_valid & rd_ready. Requires queue not full. ram_aa=rd_srca, ram_ab=rd_srcb, ram_clka=ram_clkb=1, both strobes=1.
  - WRITE: queue non-empty and no READ. ram_ab=head.addr, ram_db=head.data, ram_nweb=0, ram_clkb=1; pop head.
  - IDLE: all RAM controls at reset values.
- rd_ready = !full (plus the forwarding stall rule when GPU_REGFWD_EN is not defined). A full queue forces a drain, so writes never starve.
- Latency: op_valid is asserted exactly 1 cycle after acceptance. There is no output backpressure.
- Coherency: a fetch returns the newest value from the RAM contents plus queue entries present at the start of the acceptance cycle. An entry pushed in the same cycle as the fetch is not visible to that fetch.
- Forwarding: at acceptance, each source compares against all valid queue entries. The youngest match wins. The match flag and data are registered and muxed over ram_qa/ram_qb in the output cycle.
- srca==srcb is legal; both outputs carry identical values.
- Address wrap: AW-bit compare only; register 63 is not special.

Optional Feature:
- Macro: GPU_REGFWD_EN.
- Defined: forwarding as described above; rd_ready = !full.
- Undefined: no forwarding datapath. rd_ready = !full & no queue entry matches rd_srca or rd_srcb, so the fetch stalls while WRITE cycles drain the matching entries. op_a/op_b come straight from ram_qa/ram_qb.

Decomposition:
- Shared package gpu_regfile_pkg holds:
  - AW and DW constants.
  - wb_entry typedef {addr,data}.
  - Arbitration-state enum {IDLE,READ,WRITE}.
- Natural sub-module: gpu_wb_queue. It implements the FIFO with per-entry addr/valid taps and the youngest-match lookup, taking two lookup addresses and returning hit/data per lookup.

Test Plan:
- Reset, then write 0x1234_5678 to r5 with no reads → exactly one WRITE cycle with ram_ab=5, ram_nweb=0; later fetch of (5,5) → op_a=op_b=0x12345678 one cycle after accept.
- Push r3=0xA then r3=0xB (queue holding both, reads pending) and fetch (3,7), r7=0x77 in RAM:
  - forwarding build → op_a=0xB, op_b=0x77;
  - non-forwarding build → rd_ready low until both r3 entries drain, then op_a=0xB.
- Hold rd_valid continuously and push 4 writebacks (WB_DEPTH=4) → rd_ready drops when the queue is full, one WRITE cycle drains an entry, rd_ready returns; no writeback lost.
- Fetch (9,9) in the same cycle wb pushes r9=0x55, with RAM r9=0x11 → op_a=op_b=0x11; next fetch of r9 after drain → 0x55.
- Assert sys_rst with 3 queued writes and a fetch accepted the previous cycle → op_valid=0 next cycle, queue empty, none of the 3 writes reach the RAM.

Source files
------------

// File: rtl/gpu_regfile_pkg.sv
// Shared widths, writeback entry layout and arbitration states for the GPU
// register-file access controller.
package gpu_regfile_pkg;

    localparam int AW = 6;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } arb_state_e;

endpackage

// File: rtl/gpu_wb_queue.sv
// Writeback FIFO with per-slot valid taps and a youngest-match lookup for two
// source addresses; lookup data outputs exist only when GPU_REGFWD_EN is defined.
module gpu_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = gpu_regfile_pkg::AW,
    parameter int DW    = gpu_regfile_pkg::DW
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    input  logic [AW-1:0] look_a,
    input  logic [AW-1:0] look_b,
    output logic          hit_a,
    output logic          hit_b
`ifdef GPU_REGFWD_EN
    ,
    output logic [DW-1:0] fwd_a,
    output logic [DW-1:0] fwd_b
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] vld;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];

    function automatic logic [PW-1:0] age_idx(input logic [PW-1:0] base, input int k);
        return base + PW'(k);
    endfunction

    assign full      = vld[wr_ptr];
    assign empty     = !vld[rd_ptr];
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            vld    <= '0;
        end else begin
            if (push) begin
                vld[wr_ptr] <= 1'b1;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: the entry storage has no reset; the valid bits alone decide which
    // slots are live, so stale contents after reset are never observed.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    // Scan oldest to youngest so that a later match overrides an earlier one.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
`ifdef GPU_REGFWD_EN
        fwd_a = '0;
        fwd_b = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            if (vld[age_idx(rd_ptr, k)] && addr_q[age_idx(rd_ptr, k)] == look_a) begin
                hit_a = 1'b1;
`ifdef GPU_REGFWD_EN
                fwd_a = data_q[age_idx(rd_ptr, k)];
`endif
            end
            if (vld[age_idx(rd_ptr, k)] && addr_q[age_idx(rd_ptr, k)] == look_b) begin
                hit_b = 1'b1;
`ifdef GPU_REGFWD_EN
                fwd_b = data_q[age_idx(rd_ptr, k)];
`endif
            end
        end
    end

endmodule

// File: rtl/gpu_regfile_ctl.sv
// Register-file access controller: arbitrates operand fetches against queued
// writebacks on a dual-port RAM. GPU_REGFWD_EN selects forwarding over stalling.
module gpu_regfile_ctl #(
    parameter int WB_DEPTH = 4,
    parameter int AW       = gpu_regfile_pkg::AW,
    parameter int DW       = gpu_regfile_pkg::DW
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_srca,
    input  logic [AW-1:0] rd_srcb,
    output logic          op_valid,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [AW-1:0] ram_aa,
    output logic [DW-1:0] ram_da,
    output logic          ram_nwea,
    output logic          ram_clka,
    output logic [AW-1:0] ram_ab,
    output logic [DW-1:0] ram_db,
    output logic          ram_nweb,
    output logic          ram_clkb,
    input  logic [DW-1:0] ram_qa,
    input  logic [DW-1:0] ram_qb
);
    import gpu_regfile_pkg::*;

    logic          q_full;
    logic          q_empty;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          hit_a;
    logic          hit_b;
    logic          wb_push;
    arb_state_e    arb;

    assign wb_ready = !sys_rst && !q_full;
    assign wb_push  = wb_valid && wb_ready;

`ifdef GPU_REGFWD_EN
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;
    logic          fwd_hit_a_q;
    logic          fwd_hit_b_q;
    logic [DW-1:0] fwd_data_a_q;
    logic [DW-1:0] fwd_data_b_q;

    assign rd_ready = !sys_rst && !q_full;
`else
    // A pending writeback to either source blocks the fetch until it drains.
    assign rd_ready = !sys_rst && !q_full && !hit_a && !hit_b;
`endif

    gpu_wb_queue #(
        .DEPTH (WB_DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_wb_queue (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push      (wb_push),
        .push_addr (wb_addr),
        .push_data (wb_data),
        .pop       (arb == WRITE),
        .full      (q_full),
        .empty     (q_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .look_a    (rd_srca),
        .look_b    (rd_srcb),
        .hit_a     (hit_a),
        .hit_b     (hit_b)
`ifdef GPU_REGFWD_EN
        ,
        .fwd_a     (fwd_a),
        .fwd_b     (fwd_b)
`endif
    );

    // Reads win the cycle; a full queue drops rd_ready, which forces a drain.
    always_comb begin
        arb = IDLE;
        if (!sys_rst) begin
            if (rd_valid && rd_ready) begin
                arb = READ;
            end else if (!q_empty) begin
                arb = WRITE;
            end
        end
    end

    // RAM controls stay combinational so the registered RAM answers one cycle later.
    assign ram_da   = '0;
    assign ram_nwea = 1'b1;

    always_comb begin
        ram_aa   = '0;
        ram_clka = 1'b0;
        ram_ab   = '0;
        ram_db   = '0;
        ram_nweb = 1'b1;
        ram_clkb = 1'b0;
        case (arb)
            READ: begin
                ram_aa   = rd_srca;
                ram_ab   = rd_srcb;
                ram_clka = 1'b1;
                ram_clkb = 1'b1;
            end
            WRITE: begin
                ram_ab   = head_addr;
                ram_db   = head_data;
                ram_nweb = 1'b0;
                ram_clkb = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            op_valid     <= 1'b0;
`ifdef GPU_REGFWD_EN
            fwd_hit_a_q  <= 1'b0;
            fwd_hit_b_q  <= 1'b0;
            fwd_data_a_q <= '0;
            fwd_data_b_q <= '0;
`endif
        end else begin
            op_valid <= (arb == READ);
`ifdef GPU_REGFWD_EN
            if (arb == READ) begin
                fwd_hit_a_q  <= hit_a;
                fwd_hit_b_q  <= hit_b;
                fwd_data_a_q <= fwd_a;
                fwd_data_b_q <= fwd_b;
            end
`endif
        end
    end

`ifdef GPU_REGFWD_EN
    assign op_a = !op_valid ? '0 : (fwd_hit_a_q ? fwd_data_a_q : ram_qa);
    assign op_b = !op_valid ? '0 : (fwd_hit_b_q ? fwd_data_b_q : ram_qb);
`else
    assign op_a = op_valid ? ram_qa : '0;
    assign op_b = op_valid ? ram_qb : '0;
`endif

endmodule

// File: tb/tb_gpu_regfile_ctl.sv
// Directed bench for gpu_regfile_ctl with a behavioural 64x32 dual-port RAM;
// expectations adapt to whether GPU_REGFWD_EN is defined.
module tb_gpu_regfile_ctl;
    import gpu_regfile_pkg::*;

    localparam int WB_DEPTH = 4;

`ifdef GPU_REGFWD_EN
    localparam int EXP_STALL_DUP  = 0;
    localparam int EXP_STALL_WRAP = 0;
`else
    localparam int EXP_STALL_DUP  = 2;
    localparam int EXP_STALL_WRAP = 1;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_srca;
    logic [AW-1:0] rd_srcb;
    logic          op_valid;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] ram_aa;
    logic [DW-1:0] ram_da;
    logic          ram_nwea;
    logic          ram_clka;
    logic [AW-1:0] ram_ab;
    logic [DW-1:0] ram_db;
    logic          ram_nweb;
    logic          ram_clkb;
    logic [DW-1:0] ram_qa = '0;
    logic [DW-1:0] ram_qb = '0;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [64];
    wb_entry_t     wr_log [$];
    wb_entry_t     mon_e;

    always #5 sys_clk = ~sys_clk;

    gpu_regfile_ctl #(.WB_DEPTH(WB_DEPTH)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_srca  (rd_srca),
        .rd_srcb  (rd_srcb),
        .op_valid (op_valid),
        .op_a     (op_a),
        .op_b     (op_b),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .ram_aa   (ram_aa),
        .ram_da   (ram_da),
        .ram_nwea (ram_nwea),
        .ram_clka (ram_clka),
        .ram_ab   (ram_ab),
        .ram_db   (ram_db),
        .ram_nweb (ram_nweb),
        .ram_clkb (ram_clkb),
        .ram_qa   (ram_qa),
        .ram_qb   (ram_qb)
    );

    // Registered RAM: reads see the contents before this edge's write.
    always @(posedge sys_clk) begin
        if (ram_clka === 1'b1) ram_qa <= mem[ram_aa];
        if (ram_clkb === 1'b1 && ram_nweb === 1'b1) ram_qb <= mem[ram_ab];
        if (ram_clkb === 1'b1 && ram_nweb === 1'b0) mem[ram_ab] = ram_db;
    end

    always @(negedge sys_clk) begin
        if (ram_clkb === 1'b1 && ram_nweb === 1'b0) begin
            mon_e.addr = ram_ab;
            mon_e.data = ram_db;
            wr_log.push_back(mon_e);
        end
    end

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_accept(output int stalls, output bit ok);
        stalls = 0;
        while (rd_ready !== 1'b1 && stalls < 16) begin
            stalls++;
            tick();
            @(negedge sys_clk);
        end
        ok = (rd_ready === 1'b1);
    endtask

    task automatic test_reset;
        sys_rst = 1'b1; rd_valid = 1'b1; rd_srca = 6'd5; rd_srcb = 6'd6;
        wb_valid = 1'b1; wb_addr = 6'd5; wb_data = 32'hDEAD0005;
        tick(); tick();
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rst_op_valid: got %0h want 0", op_valid); end
        checks++; if (op_a !== 32'h0 || op_b !== 32'h0) begin errors++; $display("FAIL rst_op_data: got %h/%h want 0/0", op_a, op_b); end
        checks++; if ({ram_clka, ram_clkb, ram_nwea, ram_nweb} !== 4'b0011) begin errors++; $display("FAIL rst_ram_ctl: got %b want 0011", {ram_clka, ram_clkb, ram_nwea, ram_nweb}); end
        checks++; if (ram_aa !== 6'd0 || ram_ab !== 6'd0 || ram_db !== 32'h0 || ram_da !== 32'h0) begin errors++; $display("FAIL rst_ram_bus: got aa=%0d ab=%0d db=%h da=%h want zeros", ram_aa, ram_ab, ram_db, ram_da); end
        tick();
        sys_rst = 1'b0; rd_valid = 1'b0; wb_valid = 1'b0;
        tick();
        @(negedge sys_clk);
        checks++; if (wb_ready !== 1'b1 || rd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got wb=%b rd=%b want 1/1", wb_ready, rd_ready); end
        checks++; if (ram_clkb !== 1'b0) begin errors++; $display("FAIL rst_queue_empty: got ram_clkb=%b want 0", ram_clkb); end
        tick();
    endtask

    task automatic test_write_read;
        int base;
        base = wr_log.size();
        wb_valid = 1'b1; wb_addr = 6'd5; wb_data = 32'h12345678;
        @(negedge sys_clk);
        checks++; if (wb_ready !== 1'b1 || ram_clkb !== 1'b0) begin errors++; $display("FAIL wr_push_cycle: got wb_ready=%b clkb=%b want 1/0", wb_ready, ram_clkb); end
        tick();
        wb_valid = 1'b0;
        @(negedge sys_clk);
        checks++; if ({ram_clkb, ram_nweb} !== 2'b10 || ram_ab !== 6'd5 || ram_db !== 32'h12345678) begin errors++; $display("FAIL wr_write_cycle: got clkb=%b nweb=%b ab=%0d db=%h want 1/0/5/12345678", ram_clkb, ram_nweb, ram_ab, ram_db); end
        tick();
        @(negedge sys_clk);
        checks++; if (ram_clkb !== 1'b0) begin errors++; $display("FAIL wr_idle_after: got clkb=%b want 0", ram_clkb); end
        tick(); tick();
        checks++; if (wr_log.size() - base != 1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_log.size() - base); end
        rd_valid = 1'b1; rd_srca = 6'd5; rd_srcb = 6'd5;
        @(negedge sys_clk);
        checks++; if (rd_ready !== 1'b1 || {ram_clka, ram_clkb, ram_nweb} !== 3'b111 || ram_aa !== 6'd5 || ram_ab !== 6'd5) begin errors++; $display("FAIL rd_read_cycle: got rdy=%b ctl=%b aa=%0d ab=%0d want 1/111/5/5", rd_ready, {ram_clka, ram_clkb, ram_nweb}, ram_aa, ram_ab); end
        tick();
        rd_valid = 1'b0;
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h12345678 || op_b !== 32'h12345678) begin errors++; $display("FAIL rd_r5_result: got v=%b a=%h b=%h want 1/12345678/12345678", op_valid, op_a, op_b); end
        tick();
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse_width: got op_valid=%b want 0", op_valid); end
        tick();
    endtask

    task automatic test_youngest;
        int  base;
        int  stalls;
        bit  ok;
        base = wr_log.size();
        wb_valid = 1'b1; wb_addr = 6'd3; wb_data = 32'hA; rd_valid = 1'b0;
        tick();
        wb_data = 32'hB; rd_valid = 1'b1; rd_srca = 6'd7; rd_srcb = 6'd7;
        @(negedge sys_clk);
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL dup_block_fetch: got rd_ready=%b want 1", rd_ready); end
        tick();
        wb_valid = 1'b0; rd_srca = 6'd3; rd_srcb = 6'd7;
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h77 || op_b !== 32'h77) begin errors++; $display("FAIL dup_r7_result: got v=%b a=%h b=%h want 1/77/77", op_valid, op_a, op_b); end
        wait_accept(stalls, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dup_accept_timeout: got no accept want accept"); end
        checks++; if (stalls != EXP_STALL_DUP) begin errors++; $display("FAIL dup_stalls: got %0d want %0d", stalls, EXP_STALL_DUP); end
        tick();
        rd_valid = 1'b0;
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hB || op_b !== 32'h77) begin errors++; $display("FAIL dup_result: got v=%b a=%h b=%h want 1/b/77", op_valid, op_a, op_b); end
        repeat (6) tick();
        checks++; if (wr_log.size() - base != 2) begin errors++; $display("FAIL dup_wr_count: got %0d want 2", wr_log.size() - base); end
        else begin
            checks++; if (wr_log[base].addr !== 6'd3 || wr_log[base].data !== 32'hA || wr_log[base+1].addr !== 6'd3 || wr_log[base+1].data !== 32'hB) begin errors++; $display("FAIL dup_wr_order: got %0d:%h %0d:%h want 3:a 3:b", wr_log[base].addr, wr_log[base].data, wr_log[base+1].addr, wr_log[base+1].data); end
        end
    endtask

    task automatic test_full_drain;
        int base;
        base = wr_log.size();
        rd_valid = 1'b1; rd_srca = 6'd20; rd_srcb = 6'd21;
        for (int k = 0; k < WB_DEPTH; k++) begin
            wb_valid = 1'b1; wb_addr = 6'(10 + k); wb_data = 32'h100 + 32'(k);
            @(negedge sys_clk);
            checks++; if (wb_ready !== 1'b1 || rd_ready !== 1'b1 || ram_clka !== 1'b1) begin errors++; $display("FAIL full_fill_%0d: got wb=%b rd=%b clka=%b want 1/1/1", k, wb_ready, rd_ready, ram_clka); end
            tick();
        end
        wb_addr = 6'd14; wb_data = 32'h999;
        @(negedge sys_clk);
        checks++; if (rd_ready !== 1'b0 || wb_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got rd=%b wb=%b want 0/0", rd_ready, wb_ready); end
        checks++; if ({ram_clkb, ram_nweb} !== 2'b10 || ram_ab !== 6'd10 || ram_db !== 32'h100) begin errors++; $display("FAIL full_drain: got clkb=%b nweb=%b ab=%0d db=%h want 1/0/10/100", ram_clkb, ram_nweb, ram_ab, ram_db); end
        checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL full_last_op: got op_valid=%b want 1", op_valid); end
        tick();
        wb_valid = 1'b0;
        @(negedge sys_clk);
        checks++; if (rd_ready !== 1'b1 || op_valid !== 1'b0) begin errors++; $display("FAIL full_recover: got rd=%b op_valid=%b want 1/0", rd_ready, op_valid); end
        tick();
        rd_valid = 1'b0;
        repeat (6) tick();
        checks++; if (wr_log.size() - base != WB_DEPTH) begin errors++; $display("FAIL full_wr_count: got %0d want %0d", wr_log.size() - base, WB_DEPTH); end
        else begin
            for (int k = 0; k < WB_DEPTH; k++) begin
                checks++; if (wr_log[base+k].addr !== 6'(10 + k) || wr_log[base+k].data !== 32'h100 + 32'(k)) begin errors++; $display("FAIL full_wr_%0d: got %0d:%h want %0d:%h", k, wr_log[base+k].addr, wr_log[base+k].data, 10 + k, 32'h100 + 32'(k)); end
            end
        end
    endtask

    task automatic test_same_cycle;
        wb_valid = 1'b1; wb_addr = 6'd9; wb_data = 32'h55;
        rd_valid = 1'b1; rd_srca = 6'd9; rd_srcb = 6'd9;
        @(negedge sys_clk);
        checks++; if (rd_ready !== 1'b1 || wb_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got rd=%b wb=%b want 1/1", rd_ready, wb_ready); end
        tick();
        wb_valid = 1'b0; rd_valid = 1'b0;
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h11 || op_b !== 32'h11) begin errors++; $display("FAIL same_old_value: got v=%b a=%h b=%h want 1/11/11", op_valid, op_a, op_b); end
        checks++; if ({ram_clkb, ram_nweb} !== 2'b10 || ram_ab !== 6'd9) begin errors++; $display("FAIL same_drain: got clkb=%b nweb=%b ab=%0d want 1/0/9", ram_clkb, ram_nweb, ram_ab); end
        tick(); tick();
        rd_valid = 1'b1;
        @(negedge sys_clk);
        tick();
        rd_valid = 1'b0;
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h55 || op_b !== 32'h55) begin errors++; $display("FAIL same_new_value: got v=%b a=%h b=%h want 1/55/55", op_valid, op_a, op_b); end
        tick();
    endtask

    task automatic test_wrap;
        int stalls;
        bit ok;
        wb_valid = 1'b1; wb_addr = 6'd63; wb_data = 32'hCAFE0063;
        rd_valid = 1'b1; rd_srca = 6'd1; rd_srcb = 6'd2;
        tick();
        wb_valid = 1'b0; rd_srca = 6'd63; rd_srcb = 6'd0;
        @(negedge sys_clk);
        wait_accept(stalls, ok);
        checks++; if (!ok || stalls != EXP_STALL_WRAP) begin errors++; $display("FAIL wrap_accept: got ok=%b stalls=%0d want 1/%0d", ok, stalls, EXP_STALL_WRAP); end
        tick();
        rd_valid = 1'b0;
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hCAFE0063 || op_b !== 32'hF00) begin errors++; $display("FAIL wrap_result: got v=%b a=%h b=%h want 1/cafe0063/f00", op_valid, op_a, op_b); end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid;
        int base;
        base = wr_log.size();
        rd_valid = 1'b1; rd_srca = 6'd50; rd_srcb = 6'd51;
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1'b1; wb_addr = 6'(40 + k); wb_data = 32'hA0 + 32'(k);
            tick();
        end
        wb_valid = 1'b0; sys_rst = 1'b1;
        @(negedge sys_clk);
        checks++; if (ram_clka !== 1'b0 || ram_clkb !== 1'b0) begin errors++; $display("FAIL midrst_ram_idle: got clka=%b clkb=%b want 0/0", ram_clka, ram_clkb); end
        tick();
        sys_rst = 1'b0; rd_valid = 1'b0;
        @(negedge sys_clk);
        checks++; if (op_valid !== 1'b0 || op_a !== 32'h0) begin errors++; $display("FAIL midrst_op: got v=%b a=%h want 0/0", op_valid, op_a); end
        checks++; if (wb_ready !== 1'b1 || ram_clkb !== 1'b0) begin errors++; $display("FAIL midrst_queue: got wb_ready=%b clkb=%b want 1/0", wb_ready, ram_clkb); end
        repeat (6) tick();
        checks++; if (wr_log.size() != base) begin errors++; $display("FAIL midrst_no_writes: got %0d writes want 0", wr_log.size() - base); end
    endtask

    initial begin
        sys_rst = 1'b1; rd_valid = 1'b0; wb_valid = 1'b0;
        rd_srca = '0; rd_srcb = '0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'hF00;
        mem[7] = 32'h77;
        mem[9] = 32'h11;

        test_reset();
        test_write_read();
        test_youngest();
        test_full_drain();
        test_same_cycle();
        test_wrap();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
